// File: rtl/pm_boot_mem_pkg.sv
// Shared definitions for the program-memory boot responder: boot FSM states,
// the word width and the NOP encoding returned when the sequencer is gated.
package pm_boot_mem_pkg;

  localparam int PM_WORD_W = 32;

  localparam logic [PM_WORD_W-1:0] PM_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_LOAD = 2'd1,
    B_RUN  = 2'd2
  } boot_state_t;

endpackage

// File: rtl/pm_sram_1p.sv
// Single-port synchronous RAM, PM_DEPTH x 32, registered read, no array reset.
// A write takes priority; the read register holds when neither port strobe is set.
module pm_sram_1p
  import pm_boot_mem_pkg::*;
#(
  parameter int PM_DEPTH = 256,
  parameter int PM_AW    = 8
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [PM_AW-1:0]     i_addr,
  input  logic [PM_WORD_W-1:0] i_wdata,
  output logic [PM_WORD_W-1:0] o_rdata
);

  logic [PM_WORD_W-1:0] r_mem [PM_DEPTH];
  logic [PM_WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pm_boot_mem.sv
// Program-memory responder for the sequencer PM fetch port, with a boot FSM
// that fills memory from a byte stream and holds the sequencer in reset until done.
module pm_boot_mem
  import pm_boot_mem_pkg::*;
#(
  parameter int PM_DEPTH   = 256,
  parameter int PM_AW      = 8,
  parameter int BOOT_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps_pm_cslt,
  input  logic        ps_pm_wrb,
  input  logic [15:0] ps_pm_add,
  input  logic [31:0] ps_pm_dt,
  output logic [31:0] pm_ps_op,
  input  logic        boot_en,
  input  logic        boot_vld,
  input  logic [7:0]  boot_byte,
  output logic        boot_rdy,
  output logic        pm_boot_done,
  output logic        pm_ps_rstn
);

  boot_state_t r_state, w_state_next;

  logic [1:0]           r_byte_cnt;
  logic [PM_AW-1:0]     r_word_cnt;
  logic [23:0]          r_asm;
  logic                 r_boot_rdy;
  logic                 r_done;
  logic                 r_rstn;
  logic                 r_rd_pend;
  logic [PM_WORD_W-1:0] r_op_hold;

  logic                 w_byte_acc;
  logic                 w_word_wr;
  logic                 w_last_word;
  logic                 w_run;
  logic                 w_in_range;
  logic                 w_seq_rd;
  logic                 w_seq_wr;
  logic                 w_ram_we;
  logic                 w_ram_re;
  logic [PM_AW-1:0]     w_ram_addr;
  logic [PM_WORD_W-1:0] w_ram_wdata;
  logic [PM_WORD_W-1:0] w_ram_q;
  logic [PM_WORD_W-1:0] w_op;

  assign w_byte_acc  = boot_vld & r_boot_rdy;
  assign w_word_wr   = w_byte_acc & (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_cnt == PM_AW'(BOOT_WORDS - 1));

  assign w_run      = (r_state == B_RUN);
  assign w_in_range = ({1'b0, ps_pm_add} < 17'(PM_DEPTH));
  assign w_seq_rd   = w_run & ps_pm_cslt & ~ps_pm_wrb;
  assign w_seq_wr   = w_run & ps_pm_cslt & ps_pm_wrb;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      B_IDLE:  w_state_next = boot_en ? B_LOAD : B_RUN;
      B_LOAD:  if (w_word_wr && w_last_word) w_state_next = B_RUN;
      B_RUN:   w_state_next = B_RUN;
      default: w_state_next = B_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge the FSM moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= B_IDLE;
      r_boot_rdy <= 1'b0;
      r_done     <= 1'b0;
      r_rstn     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_boot_rdy <= (w_state_next == B_LOAD);
      r_done     <= (w_state_next == B_RUN);
      r_rstn     <= (w_state_next == B_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= 2'd0;
      r_word_cnt <= '0;
      r_asm      <= 24'd0;
    end else if (w_byte_acc) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_asm      <= {r_asm[15:0], boot_byte};
      if (w_word_wr) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  // The boot writer owns the RAM port in B_LOAD, the sequencer only in B_RUN.
  assign w_ram_we    = w_word_wr | (w_seq_wr & w_in_range);
  assign w_ram_re    = w_seq_rd & w_in_range;
  assign w_ram_addr  = (r_state == B_LOAD) ? r_word_cnt : ps_pm_add[PM_AW-1:0];
  assign w_ram_wdata = (r_state == B_LOAD) ? {r_asm, boot_byte} : ps_pm_dt;

  pm_sram_1p #(
    .PM_DEPTH(PM_DEPTH),
    .PM_AW   (PM_AW)
  ) u_sram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_q)
  );

  // After an in-range read the RAM register is shown directly; otherwise the
  // last shown value is held, or forced to NOP by an out-of-range read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend <= 1'b0;
      r_op_hold <= PM_NOP;
    end else if (w_seq_rd) begin
      r_rd_pend <= w_in_range;
      r_op_hold <= w_in_range ? w_op : PM_NOP;
    end else begin
      r_rd_pend <= 1'b0;
      r_op_hold <= w_op;
    end
  end

  assign w_op = r_rd_pend ? w_ram_q : r_op_hold;

  assign pm_ps_op     = w_run ? w_op : PM_NOP;
  assign boot_rdy     = r_boot_rdy;
  assign pm_boot_done = r_done;
  assign pm_ps_rstn   = r_rstn;

endmodule

// File: tb/tb_pm_boot_mem.sv
// Randomized bench for pm_boot_mem against a byte-queue / word-array reference model.
module tb_pm_boot_mem;

  localparam int DEPTH = 256;
  localparam int BW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cslt = 1'b0;
  logic        wrb = 1'b0;
  logic [15:0] add = 16'd0;
  logic [31:0] dt = 32'd0;
  logic [31:0] op;
  logic        boot_en = 1'b0;
  logic        boot_vld = 1'b0;
  logic [7:0]  boot_byte = 8'd0;
  logic        boot_rdy;
  logic        done;
  logic        rstn;

  pm_boot_mem #(
    .PM_DEPTH  (DEPTH),
    .PM_AW     (8),
    .BOOT_WORDS(BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps_pm_cslt  (cslt),
    .ps_pm_wrb   (wrb),
    .ps_pm_add   (add),
    .ps_pm_dt    (dt),
    .pm_ps_op    (op),
    .boot_en     (boot_en),
    .boot_vld    (boot_vld),
    .boot_byte   (boot_byte),
    .boot_rdy    (boot_rdy),
    .pm_boot_done(done),
    .pm_ps_rstn  (rstn)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 = idle, 1 = loading, 2 = running.
  int          m_phase = 0;
  logic [7:0]  m_q[$];
  int          m_words = 0;
  logic [31:0] m_mem[DEPTH];
  logic [31:0] m_op = 32'd0;

  logic [7:0] bstr [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %08h want %08h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_outs();
    chk("op", op, m_op);
    chk("boot_rdy", 32'(boot_rdy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("rstn", 32'(rstn), 32'(m_phase == 2));
  endtask

  task automatic step();
    @(posedge clk);
    case (m_phase)
      0: m_phase = boot_en ? 1 : 2;
      1: if (boot_vld) begin
           m_q.push_back(boot_byte);
           if (m_q.size() == 4) begin
             m_mem[m_words] = {m_q[0], m_q[1], m_q[2], m_q[3]};
             m_q.delete();
             m_words++;
             if (m_words == BW) m_phase = 2;
           end
         end
      default: if (cslt) begin
           if (wrb) begin
             if (int'(add) < DEPTH) m_mem[add[7:0]] = dt;
           end else begin
             m_op = (int'(add) < DEPTH) ? m_mem[add[7:0]] : 32'd0;
           end
         end
    endcase
    @(negedge clk);
    $display("t=%0t cs=%b wr=%b a=%04h vld=%b b=%02h | op=%08h rdy=%b done=%b rstn=%b",
             $time, cslt, wrb, add, boot_vld, boot_byte, op, boot_rdy, done, rstn);
    chk_outs();
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst = 1'b0; boot_en = en; boot_vld = 1'b0; cslt = 1'b0;
    m_phase = 0; m_q.delete(); m_words = 0; m_op = 32'd0;
    #1;
    chk_outs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic seq(input logic c, input logic w, input logic [15:0] a, input logic [31:0] d);
    cslt = c; wrb = w; add = a; dt = d;
    step();
  endtask

  task automatic send(input logic v, input logic [7:0] b);
    boot_vld = v; boot_byte = b;
    step();
  endtask

  initial begin
    // Boot with boot_vld held high; sequencer writes during load must be ignored.
    do_reset(1'b1);
    step();
    cslt = 1'b1; wrb = 1'b1; add = 16'd0; dt = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) send(1'b1, bstr[i]);
    cslt = 1'b0;
    send(1'b1, 8'hAA);
    boot_vld = 1'b0;
    seq(1'b1, 1'b0, 16'h0000, 32'd0);
    chk("boot_w0", op, 32'h1234_5678);
    seq(1'b1, 1'b0, 16'h0001, 32'd0);
    chk("boot_w1", op, 32'h9ABC_DEF0);

    // Sequencer write/read, out-of-range read, hold on write and idle.
    seq(1'b1, 1'b1, 16'h0003, 32'h8A00_0005);
    chk("hold_wr", op, 32'h9ABC_DEF0);
    seq(1'b0, 1'b0, 16'h0000, 32'd0);
    seq(1'b1, 1'b0, 16'h0003, 32'd0);
    chk("rd3", op, 32'h8A00_0005);
    seq(1'b0, 1'b0, 16'h0001, 32'd0);
    chk("hold_idle", op, 32'h8A00_0005);
    seq(1'b1, 1'b0, 16'h0100, 32'd0);
    chk("rd_oor", op, 32'h0);

    // Gapped stream gives identical contents.
    do_reset(1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, bstr[i]);
      send(1'b0, 8'($urandom));
    end
    boot_vld = 1'b0;
    seq(1'b1, 1'b0, 16'h0000, 32'd0);
    chk("gap_w0", op, 32'h1234_5678);
    seq(1'b1, 1'b0, 16'h0001, 32'd0);
    chk("gap_w1", op, 32'h9ABC_DEF0);

    // Direct run: done one cycle after release, reads usable immediately.
    do_reset(1'b0);
    step();
    seq(1'b1, 1'b0, 16'h0001, 32'd0);
    chk("direct_rd1", op, 32'h9ABC_DEF0);

    // Fill the whole array, then random sequencer traffic.
    for (int i = 0; i < DEPTH; i++) seq(1'b1, 1'b1, 16'(i), $urandom);
    for (int i = 0; i < 300; i++) begin
      seq(($urandom % 4) != 0, $urandom % 2,
          ($urandom % 8 == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom % DEPTH),
          $urandom);
    end
    cslt = 1'b0;

    // Reset after 5 bytes, then a full randomly gapped reload from byte 0.
    do_reset(1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      boot_en = $urandom % 2;
      send(1'b1, 8'($urandom));
    end
    do_reset(1'b1);
    step();
    while (m_phase != 2) send($urandom % 2, 8'($urandom));
    boot_vld = 1'b0;
    for (int i = 0; i < 2; i++) seq(1'b1, 1'b0, 16'(i), 32'd0);

    // Reset after 5 bytes, then direct run: word 0 kept, word 1 untouched.
    do_reset(1'b1);
    step();
    for (int i = 0; i < 5; i++) send(1'b1, 8'($urandom));
    do_reset(1'b0);
    step();
    for (int i = 0; i < 2; i++) seq(1'b1, 1'b0, 16'(i), 32'd0);
    for (int i = 0; i < 40; i++) seq($urandom % 2, $urandom % 2, 16'($urandom % DEPTH), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
